ignition_sequencer_multi: RTL

- Parametrised next-generation ignition controller: one block drives all NUM_CYL ignition coils instead of one ignition_control instance per cylinder.
- Adds per-channel timed dwell with clamp, missed-spark detection, wasted-spark pairing mode, and sticky fault flags.
- Sits downstream of stroke_transition (stroke, allow_ignition, ic_on) and crank_position_control (crank_tick); btdc_ready comes from the BTDC calculator.

---
 rtl/ignition_sequencer_multi_if.sv | 39 +++
 rtl/ignition_sequencer_multi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ignition_sequencer_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : ignition_sequencer_multi_if
// Purpose  : Bundles the per-cylinder control inputs and coil/status outputs
//            of ignition_sequencer_multi into one interface.
// Ports    : on, mode, stroke, allow_ignition, btdc_ready, crank_tick,
//            dwell_cycles    -> driven by the master, consumed by the sequencer
//            ignite, cal_ignition, spark_done, miss, clamp
//                            -> driven by the sequencer (slave)
// Revision : 1.0 - initial release
// ============================================================================
interface ignition_sequencer_multi_if #(
  parameter int NUM_CYL = 4,
  parameter int DWELL_W = 16
);
  logic [NUM_CYL-1:0]   on;
  logic                 mode;
  logic [2*NUM_CYL-1:0] stroke;
  logic [NUM_CYL-1:0]   allow_ignition;
  logic [NUM_CYL-1:0]   btdc_ready;
  logic                 crank_tick;
  logic [DWELL_W-1:0]   dwell_cycles;
  logic [NUM_CYL-1:0]   ignite;
  logic [NUM_CYL-1:0]   cal_ignition;
  logic [NUM_CYL-1:0]   spark_done;
  logic [NUM_CYL-1:0]   miss;
  logic [NUM_CYL-1:0]   clamp;

  modport master (
    output on, mode, stroke, allow_ignition, btdc_ready, crank_tick, dwell_cycles,
    input  ignite, cal_ignition, spark_done, miss, clamp
  );

  modport slave (
    input  on, mode, stroke, allow_ignition, btdc_ready, crank_tick, dwell_cycles,
    output ignite, cal_ignition, spark_done, miss, clamp
  );
endinterface
`default_nettype wire

// File: rtl/ignition_sequencer_multi.sv
`default_nettype none
// ============================================================================
// Module   : ignition_sequencer_multi
// Purpose  : Multi-channel ignition sequencer. One FSM per cylinder
//            (IDLE/ARMED/DWELL/SPARKED) with timed, clamped dwell,
//            missed-spark detection, sticky fault flags and an optional
//            wasted-spark pairing of channel i with channel i+NUM_CYL/2.
// Ports    : clk   - system clock
//            reset - synchronous active-high reset
//            bus   - ignition_sequencer_multi_if.slave (control in,
//                    coil drive and status out)
// Revision : 1.0 - initial release
// ============================================================================
module ignition_sequencer_multi #(
  parameter int NUM_CYL   = 4,
  parameter int DWELL_W   = 16,
  parameter int MAX_DWELL = 50000,
  parameter int MIN_DWELL = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  ignition_sequencer_multi_if.slave bus
);

  localparam int                 HALF        = NUM_CYL / 2;
  localparam logic [DWELL_W-1:0] C_MAX_DWELL = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] C_MIN_DWELL = DWELL_W'(MIN_DWELL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_DWELL   = 2'd2,
    S_SPARKED = 2'd3
  } state_t;

  // Static parameter sanity: the clamp limit must be representable in the
  // dwell counter, and the clamp window must not be empty.
  if (64'(MAX_DWELL) >= (64'd1 << DWELL_W)) begin : g_chk_max_dwell
    $error("MAX_DWELL does not fit in DWELL_W bits");
  end
  if (MIN_DWELL > MAX_DWELL) begin : g_chk_min_dwell
    $error("MIN_DWELL exceeds MAX_DWELL");
  end

  // Shared dwell clamp; every channel latches this at its own dwell start.
  logic [DWELL_W-1:0] dwell_clamped;
  logic               dwell_altered;

  always_comb begin
    dwell_clamped = bus.dwell_cycles;
    dwell_altered = 1'b0;
    if (bus.dwell_cycles < C_MIN_DWELL) begin
      dwell_clamped = C_MIN_DWELL;
      dwell_altered = 1'b1;
    end else if (bus.dwell_cycles > C_MAX_DWELL) begin
      dwell_clamped = C_MAX_DWELL;
      dwell_altered = 1'b1;
    end
  end

  logic [NUM_CYL-1:0] core_ign;
  logic [NUM_CYL-1:0] core_done;
  logic [NUM_CYL-1:0] core_cal;
  logic [NUM_CYL-1:0] core_miss;
  logic [NUM_CYL-1:0] core_clamp;
  logic [NUM_CYL-1:0] core_idle;

  for (genvar i = 0; i < NUM_CYL; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               btdc_prev_q;
    logic               cal_q, cal_d;
    logic               done_q, done_d;
    logic               miss_q, miss_d;
    logic               clamp_q, clamp_d;
    logic               in_comp;
    logic               btdc_rise;

    assign in_comp   = (bus.stroke[2*i +: 2] == 2'b01);
    assign btdc_rise = bus.btdc_ready[i] & ~btdc_prev_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cal_d   = 1'b0;
      done_d  = 1'b0;
      miss_d  = miss_q;
      clamp_d = clamp_q;
      if (!bus.on[i]) begin
        // Disabling a channel aborts silently: no spark report, no miss.
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.allow_ignition[i] && in_comp) begin
              state_d = S_ARMED;
              cal_d   = 1'b1;
            end
          end
          S_ARMED: begin
            // The btdc edge is checked first so it beats a coincident
            // crank tick or stroke change.
            if (btdc_rise) begin
              state_d = S_DWELL;
              cnt_d   = dwell_clamped;
              if (dwell_altered) begin
                clamp_d = 1'b1;
              end
            end else if (!bus.allow_ignition[i]) begin
              state_d = S_IDLE;
            end else if (!in_comp || bus.crank_tick) begin
              state_d = S_IDLE;
              miss_d  = 1'b1;
            end
          end
          S_DWELL: begin
            // Coil stays charged regardless of crank/stroke; only the
            // counter ends the dwell.
            if (cnt_q <= DWELL_W'(1)) begin
              state_d = S_SPARKED;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          S_SPARKED: begin
            // Held here until the compression window closes, so further
            // btdc edges in the same window cannot fire again.
            if (!in_comp) begin
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        btdc_prev_q <= 1'b0;
        cal_q       <= 1'b0;
        done_q      <= 1'b0;
        miss_q      <= 1'b0;
        clamp_q     <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        btdc_prev_q <= bus.btdc_ready[i];
        cal_q       <= cal_d;
        done_q      <= done_d;
        miss_q      <= miss_d;
        clamp_q     <= clamp_d;
      end
    end

    assign core_ign[i]   = (state_q == S_DWELL);
    assign core_idle[i]  = (state_q == S_IDLE);
    assign core_done[i]  = done_q;
    assign core_cal[i]   = cal_q;
    assign core_miss[i]  = miss_q;
    assign core_clamp[i] = clamp_q;
  end

  // Pairing mode is only allowed to change while no channel is mid-cycle,
  // so a coil pulse is never split or duplicated by a mode switch.
  logic mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (&core_idle) begin
      mode_d = bus.mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  logic [NUM_CYL-1:0] ign_out;
  logic [NUM_CYL-1:0] done_out;

  // Partner of channel i is (i + NUM_CYL/2) mod NUM_CYL, which is symmetric
  // for even NUM_CYL.
  for (genvar i = 0; i < NUM_CYL; i++) begin : g_out
    localparam int PARTNER = (i + HALF) % NUM_CYL;
    assign ign_out[i]  = core_ign[i]  | (mode_q & core_ign[PARTNER]);
    assign done_out[i] = core_done[i] | (mode_q & core_done[PARTNER]);
  end

  assign bus.ignite       = ign_out;
  assign bus.spark_done   = done_out;
  assign bus.cal_ignition = core_cal;
  assign bus.miss         = core_miss;
  assign bus.clamp        = core_clamp;

endmodule
`default_nettype wire
